// File: rtl/sph_axil_pkg.sv
// Shared types and address map for the SPH AXI4-Lite register file.
package sph_axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  localparam int unsigned REG0_OFF   = 32'h00;
  localparam int unsigned REG1_OFF   = 32'h04;
  localparam int unsigned REG2_OFF   = 32'h08;
  localparam int unsigned REG3_OFF   = 32'h0C;
  localparam int unsigned ID_OFF     = 32'h10;
  localparam int unsigned STATUS_OFF = 32'h14;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5350_4801;

  // Byte offset of RW register idx; registers are packed from REG0_OFF.
  function automatic int unsigned reg_off(input int unsigned idx);
    return REG0_OFF + 4 * idx;
  endfunction

endpackage

// File: rtl/sph_axil_regs_if.sv
// AXI4-Lite bus bundle between a master (PS / VIP) and the SPH register slave.
interface sph_axil_regs_if #(
  parameter int unsigned AddrW = 5,
  parameter int unsigned DataW = 32
);

  logic [AddrW-1:0]   awaddr;
  logic [2:0]         awprot;
  logic               awvalid;
  logic               awready;
  logic [DataW-1:0]   wdata;
  logic [DataW/8-1:0] wstrb;
  logic               wvalid;
  logic               wready;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;
  logic [AddrW-1:0]   araddr;
  logic [2:0]         arprot;
  logic               arvalid;
  logic               arready;
  logic [DataW-1:0]   rdata;
  logic [1:0]         rresp;
  logic               rvalid;
  logic               rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/sph_axil_hold.sv
// Single-entry valid/ready holding register; ready depends only on registered state.
module sph_axil_hold #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             ready_o,
  input  logic             clr_i,
  output logic             held_o,
  output logic [Width-1:0] data_o
);

  logic             held_q, held_d;
  logic [Width-1:0] data_q, data_d;

  assign ready_o = en_i && !held_q;
  assign held_o  = held_q;
  assign data_o  = data_q;

  always_comb begin
    held_d = held_q;
    data_d = data_q;
    if (clr_i) begin
      held_d = 1'b0;
    end
    if (valid_i && ready_o) begin
      held_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_q <= 1'b0;
      data_q <= '0;
    end else begin
      held_q <= held_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/sph_axil_regs.sv
// AXI4-Lite slave register file for the SPH core: RW control regs, RO ID and status.
module sph_axil_regs
  import sph_axil_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS           = 4,
  parameter logic [31:0] ID_VALUE           = ID_VALUE_DEFAULT
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  sph_axil_regs_if.slave                         s_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                    wr_pulse,
  input  logic [31:0]                            status_i
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned StrbW = DW / 8;

  logic [NUM_REGS-1:0][DW-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]         wr_pulse_q, wr_pulse_d;
  wr_state_t                   wr_state_q, wr_state_d;
  rd_state_t                   rd_state_q, rd_state_d;
  resp_t                       bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0]               rdata_q, rdata_d;
  logic                        rdy_en_q;

  logic                        aw_held, w_held, commit;
  logic [AW-1:0]               aw_addr, aw_word, ar_word;
  logic [DW-1:0]               w_data;
  logic [StrbW-1:0]            w_strb;

  // Keeps READY low through reset and until the first edge after release.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) rdy_en_q <= 1'b0;
    else                rdy_en_q <= 1'b1;
  end

  sph_axil_hold #(.Width(AW)) u_aw_hold (
    .clk_i   (S_AXI_ACLK),
    .rst_ni  (S_AXI_ARESETN),
    .en_i    (rdy_en_q),
    .valid_i (s_axi.awvalid),
    .data_i  (s_axi.awaddr),
    .ready_o (s_axi.awready),
    .clr_i   (commit),
    .held_o  (aw_held),
    .data_o  (aw_addr)
  );

  sph_axil_hold #(.Width(DW + StrbW)) u_w_hold (
    .clk_i   (S_AXI_ACLK),
    .rst_ni  (S_AXI_ARESETN),
    .en_i    (rdy_en_q),
    .valid_i (s_axi.wvalid),
    .data_i  ({s_axi.wstrb, s_axi.wdata}),
    .ready_o (s_axi.wready),
    .clr_i   (commit),
    .held_o  (w_held),
    .data_o  ({w_strb, w_data})
  );

  assign aw_word = {aw_addr[AW-1:2], 2'b00};
  assign ar_word = {s_axi.araddr[AW-1:2], 2'b00};

  // Write path: commit only from W_IDLE, so refilled holds wait for B to finish.
  always_comb begin
    wr_state_d = wr_state_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    commit     = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_held && w_held) begin
          commit     = 1'b1;
          wr_state_d = W_RESP;
          bresp_d    = SLVERR;
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (aw_word == AW'(reg_off(i))) begin
              bresp_d       = OKAY;
              wr_pulse_d[i] = 1'b1;
              for (int unsigned b = 0; b < StrbW; b++) begin
                if (w_strb[b]) regs_d[i][8*b +: 8] = w_data[8*b +: 8];
              end
            end
          end
        end
      end
      W_RESP: begin
        if (s_axi.bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Read path: data is captured at the AR handshake, so same-edge writes are not visible.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (s_axi.arvalid && s_axi.arready) begin
          rd_state_d = R_DATA;
          rdata_d    = '0;
          rresp_d    = SLVERR;
          if (ar_word == AW'(ID_OFF)) begin
            rdata_d = ID_VALUE;
            rresp_d = OKAY;
          end else if (ar_word == AW'(STATUS_OFF)) begin
            rdata_d = status_i;
            rresp_d = OKAY;
          end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (ar_word == AW'(reg_off(i))) begin
                rdata_d = regs_q[i];
                rresp_d = OKAY;
              end
            end
          end
        end
      end
      R_DATA: begin
        if (s_axi.rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      regs_q     <= '0;
      wr_pulse_q <= '0;
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      bresp_q    <= OKAY;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign s_axi.arready = rdy_en_q && (rd_state_q == R_IDLE);
  assign s_axi.bvalid  = (wr_state_q == W_RESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = (rd_state_q == R_DATA);
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;
  assign reg_q         = regs_q;
  assign wr_pulse      = wr_pulse_q;

  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, aw_addr[1:0], s_axi.araddr[1:0]};

endmodule

// File: tb/tb_sph_axil_regs.sv
// Directed self-checking bench for sph_axil_regs.
module tb_sph_axil_regs;
  import sph_axil_pkg::*;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] reg_q;
  logic [3:0]   wr_pulse;
  logic [31:0]  status_i;

  int n_assert = 0;
  int n_fail   = 0;
  int pulse_cnt [4];

  sph_axil_regs_if #(.AddrW(5), .DataW(32)) axi ();

  sph_axil_regs #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (5),
    .NUM_REGS           (4),
    .ID_VALUE           (ID_VALUE_DEFAULT)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (axi),
    .reg_q         (reg_q),
    .wr_pulse      (wr_pulse),
    .status_i      (status_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (wr_pulse[i]) pulse_cnt[i]++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output int lat);
    int t = 0;
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_hs, w_hs;
    axi.awaddr  = addr;
    axi.awvalid = 1'b1;
    axi.wdata   = data;
    axi.wstrb   = strb;
    axi.wvalid  = 1'b1;
    axi.bready  = 1'b1;
    while (!(aw_done && w_done) && t < 20) begin
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      cyc();
      t++;
      if (aw_hs) begin aw_done = 1; axi.awvalid = 1'b0; end
      if (w_hs) begin w_done = 1; axi.wvalid = 1'b0; end
    end
    lat = 0;
    while (!axi.bvalid && t < 20) begin
      cyc();
      t++;
      lat++;
    end
    chk("wr_timeout", t < 20, 1);
    resp = axi.bresp;
    cyc();
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int t = 0;
    bit hs = 0;
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    axi.rready  = 1'b1;
    while (!hs && t < 20) begin
      hs = axi.arready;
      cyc();
      t++;
    end
    axi.arvalid = 1'b0;
    while (!axi.rvalid && t < 20) begin
      cyc();
      t++;
    end
    chk("rd_timeout", t < 20, 1);
    data = axi.rdata;
    resp = axi.rresp;
    cyc();
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          lat;
    bit          ok;

    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    status_i = 32'hCAFE_0001;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", axi.awready, 0);
    chk("rst_wready", axi.wready, 0);
    chk("rst_arready", axi.arready, 0);
    chk("rst_bvalid", axi.bvalid, 0);
    chk("rst_rvalid", axi.rvalid, 0);
    chk("rst_regs", reg_q, 0);
    chk("rst_pulse", wr_pulse, 0);
    chk("rst_rdata", axi.rdata, 0);
    rst_n = 1'b1;
    #2;
    chk("rel_awready_pre_edge", axi.awready, 0);
    cyc();
    chk("rel_awready", axi.awready, 1);
    chk("rel_wready", axi.wready, 1);
    chk("rel_arready", axi.arready, 1);

    // Basic write/readback
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, resp, lat);
      chk($sformatf("wr%0d_resp", i), resp, OKAY);
      chk($sformatf("wr%0d_lat", i), lat, 1);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), rd, resp);
      chk($sformatf("rd%0d_data", i), rd, i + 1);
      chk($sformatf("rd%0d_resp", i), resp, OKAY);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("pulse%0d_count", i), pulse_cnt[i], 1);

    // Split AW then W with byte strobes
    axi_write(REG1_OFF[4:0], 32'h1122_3344, 4'hF, resp, lat);
    axi.bready  = 1'b0;
    axi.awaddr  = REG1_OFF[4:0];
    axi.awvalid = 1'b1;
    cyc();
    axi.awvalid = 1'b0;
    chk("split_aw_held", axi.awready, 0);
    cyc();
    cyc();
    axi.wdata  = 32'hDEAD_BEEF;
    axi.wstrb  = 4'b0101;
    axi.wvalid = 1'b1;
    cyc();
    axi.wvalid = 1'b0;
    chk("split_no_b_yet", axi.bvalid, 0);
    cyc();
    chk("split_bvalid", axi.bvalid, 1);
    chk("split_bresp", axi.bresp, OKAY);
    chk("split_reg1", reg_q[63:32], 32'h11AD_33EF);
    axi.bready = 1'b1;
    cyc();
    chk("split_b_done", axi.bvalid, 0);

    // B backpressure with a second write queued in the holds
    axi.bready  = 1'b0;
    axi.awaddr  = REG2_OFF[4:0];
    axi.wdata   = 32'hAAAA_5555;
    axi.wstrb   = 4'hF;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    cyc();
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    cyc();
    chk("bp_bvalid", axi.bvalid, 1);
    axi.awaddr  = REG3_OFF[4:0];
    axi.wdata   = 32'h1234_5678;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    cyc();
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    chk("bp_aw_held", axi.awready, 0);
    chk("bp_w_held", axi.wready, 0);
    ok = 1;
    repeat (4) begin
      cyc();
      if (!(axi.bvalid === 1'b1 && axi.bresp === OKAY && reg_q[127:96] === 32'h4)) ok = 0;
    end
    chk("bp_b_held", ok, 1);
    axi.bready = 1'b1;
    cyc();
    chk("bp_b_done", axi.bvalid, 0);
    chk("bp_reg3_not_yet", reg_q[127:96], 32'h4);
    cyc();
    chk("bp_second_bvalid", axi.bvalid, 1);
    chk("bp_reg3_new", reg_q[127:96], 32'h1234_5678);
    chk("bp_reg2", reg_q[95:64], 32'hAAAA_5555);
    cyc();

    // RO and unmapped accesses
    axi_read(ID_OFF[4:0], rd, resp);
    chk("id_data", rd, 32'h5350_4801);
    chk("id_resp", resp, OKAY);
    axi_read(STATUS_OFF[4:0], rd, resp);
    chk("status_data", rd, 32'hCAFE_0001);
    chk("status_resp", resp, OKAY);
    axi_write(ID_OFF[4:0], 32'hFFFF_FFFF, 4'hF, resp, lat);
    chk("wr_id_resp", resp, SLVERR);
    axi_write(5'h18, 32'hFFFF_FFFF, 4'hF, resp, lat);
    chk("wr_unmapped_resp", resp, SLVERR);
    chk("ro_regs_unchanged", reg_q,
        {32'h1234_5678, 32'hAAAA_5555, 32'h11AD_33EF, 32'h0000_0001});
    axi_read(5'h18, rd, resp);
    chk("rd_unmapped_data", rd, 0);
    chk("rd_unmapped_resp", resp, SLVERR);

    // Read handshake on the same edge as a commit to the same register
    axi_write(REG1_OFF[4:0], 32'h5, 4'hF, resp, lat);
    axi.bready  = 1'b1;
    axi.rready  = 1'b0;
    axi.awaddr  = REG1_OFF[4:0];
    axi.wdata   = 32'h9;
    axi.wstrb   = 4'hF;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    cyc();
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.araddr  = REG1_OFF[4:0];
    axi.arvalid = 1'b1;
    cyc();
    axi.arvalid = 1'b0;
    chk("same_rvalid", axi.rvalid, 1);
    chk("same_rdata_old", axi.rdata, 32'h5);
    chk("same_reg1_new", reg_q[63:32], 32'h9);
    cyc();
    chk("same_rdata_stall", axi.rdata, 32'h5);
    chk("same_rvalid_stall", axi.rvalid, 1);
    axi.rready = 1'b1;
    cyc();
    axi_read(REG1_OFF[4:0], rd, resp);
    chk("same_reread", rd, 32'h9);

    // Reset mid-transaction
    axi.bready  = 1'b0;
    axi.rready  = 1'b0;
    axi.awaddr  = REG0_OFF[4:0];
    axi.awvalid = 1'b1;
    cyc();
    axi.awvalid = 1'b0;
    chk("mid_aw_held", axi.awready, 0);
    axi.araddr  = REG0_OFF[4:0];
    axi.arvalid = 1'b1;
    cyc();
    axi.arvalid = 1'b0;
    chk("mid_rvalid_pending", axi.rvalid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", axi.rvalid, 0);
    chk("mid_rst_bvalid", axi.bvalid, 0);
    chk("mid_rst_awready", axi.awready, 0);
    chk("mid_rst_regs", reg_q, 0);
    cyc();
    rst_n      = 1'b1;
    axi.bready = 1'b1;
    axi.rready = 1'b1;
    ok = 1;
    repeat (4) begin
      cyc();
      if (axi.bvalid !== 1'b0 || axi.rvalid !== 1'b0) ok = 0;
    end
    chk("post_rst_no_stale", ok, 1);
    axi_write(REG2_OFF[4:0], 32'h77, 4'hF, resp, lat);
    chk("post_rst_wr_resp", resp, OKAY);
    chk("post_rst_regs", reg_q, {32'h0, 32'h77, 32'h0, 32'h0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
